// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L1-to-L2 round-robin arbiter.
package arb_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, scanning upward.
module rr_picker
    import arb_types::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic                 valid,
    output logic [IDX_WIDTH-1:0] idx
);

    localparam logic [IDX_WIDTH:0] SUM_N = (IDX_WIDTH+1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [IDX_WIDTH-1:0]   off;
    logic [IDX_WIDTH:0]     sum;

    always_comb begin
        // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit wins.
        dbl   = {req, req} >> rr_ptr;
        rot   = dbl[NUM_PORTS-1:0];
        valid = |req;
        off   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = IDX_WIDTH'(j);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= SUM_N) begin
            sum = sum - SUM_N;
        end
        idx = sum[IDX_WIDTH-1:0];
    end

endmodule

// File: rtl/l2_arbiter.sv
// N-port round-robin arbiter from the L1 caches onto the single L2/memory port.
module l2_arbiter
    import arb_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_resp
);

    arb_state_t            state_q, state_d;
    logic [IDX_WIDTH-1:0]  grant_q, grant_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [NUM_PORTS-1:0]  req_any;
    logic                  pick_valid;
    logic [IDX_WIDTH-1:0]  pick_idx;

    assign req_any = req_read | req_write;

    rr_picker #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_WIDTH(IDX_WIDTH)
    ) u_picker (
        .req   (req_any),
        .rr_ptr(rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d       = pick_idx;
                    mem_address_d = req_address[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d   = req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    // Read+write on one port is a write; the read is dropped.
                    mem_write_d   = req_write[pick_idx];
                    mem_read_d    = req_read[pick_idx] & ~req_write[pick_idx];
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    rr_ptr_d    = IDX_WIDTH'(rr_next(int'(grant_q), NUM_PORTS));
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Completion is steered back the same cycle; mem_resp outside BUSY never reaches a port.
    always_comb begin
        req_resp = '0;
        if (state_q == BUSY && mem_resp) begin
            req_resp[grant_q] = 1'b1;
        end
    end

    assign req_rdata   = mem_rdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter with three ports: directed vectors, queue-based monitors.
module tb_l2_arbiter;

    localparam int NP    = 3;
    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int REQ_W = 2 + AW + DW;
    localparam int RSP_W = NP + DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    req_read = '0;
    logic [NP-1:0]    req_write = '0;
    logic [NP*AW-1:0] req_address = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [DW-1:0]    req_rdata;
    logic [NP-1:0]    req_resp;
    logic             mem_read;
    logic             mem_write;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             mem_resp = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [REQ_W-1:0] exp_req_q[$];
    logic [RSP_W-1:0] exp_rsp_q[$];

    l2_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_address(req_address),
        .req_wdata  (req_wdata),
        .req_rdata  (req_rdata),
        .req_resp   (req_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[p]             = rd;
        req_write[p]            = wr;
        req_address[p*AW +: AW] = a;
        req_wdata[p*DW +: DW]   = d;
    endtask

    task automatic clr_req(input int p);
        req_read[p]  = 1'b0;
        req_write[p] = 1'b0;
    endtask

    task automatic push_req(input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_req_q.push_back({rd, wr, a, d});
    endtask

    task automatic push_rsp(input int p, input logic [DW-1:0] d);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        exp_rsp_q.push_back({v, d});
    endtask

    // Memory-side driver: wait for a downstream request, answer after lat cycles,
    // then release the requester and confirm the bubble cycle.
    task automatic serve(input int port, input int lat, input logic [DW-1:0] rdata);
        int waited;
        waited = 0;
        while (!(mem_read || mem_write) && waited < 20) begin
            step();
            waited++;
        end
        if (!(mem_read || mem_write)) begin
            tests++;
            fails++;
            $display("FAIL serve_timeout: port %0d got no downstream request, required one within 20 cycles", port);
            return;
        end
        repeat (lat) step();
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        step();
        mem_resp = 1'b0;
        clr_req(port);
        check("bubble_after_resp", 512'(mem_read || mem_write), 512'(0));
    endtask

    // ---------------- monitors / scoreboard ----------------
    initial begin
        logic             prev_active;
        logic [REQ_W-1:0] cur_req;
        prev_active = 1'b0;
        cur_req     = '0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                if (!prev_active) begin
                    if (exp_req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mem_req_unexpected: got addr %0h, required no request", mem_address);
                        cur_req = {mem_read, mem_write, mem_address, mem_wdata};
                    end else begin
                        cur_req = exp_req_q.pop_front();
                    end
                end
                check("mem_req", 512'({mem_read, mem_write, mem_address, mem_wdata}), 512'(cur_req));
            end
            prev_active = mem_read || mem_write;
        end
    end

    initial begin
        logic [RSP_W-1:0] exp_rsp;
        forever begin
            @(negedge clk);
            if (req_resp != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_resp_unexpected: got %0b, required none", req_resp);
                end else begin
                    exp_rsp = exp_rsp_q.pop_front();
                    check("req_resp", 512'({req_resp, req_rdata}), 512'(exp_rsp));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        step();
        step();
        check("rst_mem_read", 512'(mem_read), 512'(0));
        check("rst_mem_write", 512'(mem_write), 512'(0));
        check("rst_mem_address", 512'(mem_address), 512'(0));
        check("rst_mem_wdata", 512'(mem_wdata), 512'(0));
        check("rst_req_resp", 512'(req_resp), 512'(0));
        rst = 1'b0;
        step();

        // Single read from port 0, response three cycles after the first mem_read cycle
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, '0);
        push_req(1'b1, 1'b0, 32'h0000_1000, '0);
        push_rsp(0, {32{8'hA5}});
        step();
        check("read_k_plus_1", 512'(mem_read), 512'(1));
        serve(0, 3, {32{8'hA5}});

        // Spurious mem_resp while idle
        mem_resp = 1'b1;
        #1;
        check("spurious_resp", 512'(req_resp), 512'(0));
        step();
        mem_resp = 1'b0;
        check("spurious_no_req", 512'(mem_read || mem_write), 512'(0));

        // Simultaneous requests from reset: order 0,1,2
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0010, '0);
        set_req(1, 1'b0, 1'b1, 32'h0000_0020, {32{8'h11}});
        set_req(2, 1'b1, 1'b0, 32'h0000_0030, '0);
        push_req(1'b1, 1'b0, 32'h0000_0010, '0);
        push_req(1'b0, 1'b1, 32'h0000_0020, {32{8'h11}});
        push_req(1'b1, 1'b0, 32'h0000_0030, '0);
        push_rsp(0, {32{8'hC0}});
        push_rsp(1, {32{8'hC1}});
        push_rsp(2, {32{8'hC2}});
        serve(0, 1, {32{8'hC0}});
        serve(1, 1, {32{8'hC1}});
        serve(2, 2, {32{8'hC2}});

        // Round-robin wrap: serve port 1, then ports 0 and 2 compete -> 2 first
        set_req(1, 1'b1, 1'b0, 32'h0000_0040, '0);
        push_req(1'b1, 1'b0, 32'h0000_0040, '0);
        push_rsp(1, {32{8'hD1}});
        serve(1, 1, {32{8'hD1}});
        set_req(0, 1'b1, 1'b0, 32'h0000_0044, '0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0048, '0);
        push_req(1'b1, 1'b0, 32'h0000_0048, '0);
        push_req(1'b1, 1'b0, 32'h0000_0044, '0);
        push_rsp(2, {32{8'hD2}});
        push_rsp(0, {32{8'hD0}});
        serve(2, 1, {32{8'hD2}});
        serve(0, 1, {32{8'hD0}});

        // Read+write on port 1, then the address changes mid-BUSY
        set_req(1, 1'b1, 1'b1, 32'h0000_2000, {32{8'h5A}});
        push_req(1'b0, 1'b1, 32'h0000_2000, {32{8'h5A}});
        push_rsp(1, '0);
        step();
        check("rw_mem_write", 512'(mem_write), 512'(1));
        check("rw_mem_read", 512'(mem_read), 512'(0));
        check("rw_mem_wdata", 512'(mem_wdata), 512'({32{8'h5A}}));
        req_address[1*AW +: AW] = 32'h0000_3000;
        req_read[1] = 1'b0;
        step();
        check("late_addr_hold", 512'(mem_address), 512'(32'h0000_2000));
        serve(1, 2, '0);

        // Asynchronous reset with a port-1 write in flight
        set_req(1, 1'b0, 1'b1, 32'h0000_0050, {32{8'h77}});
        push_req(1'b0, 1'b1, 32'h0000_0050, {32{8'h77}});
        step();
        step();
        #1;
        rst      = 1'b1;
        mem_resp = 1'b1;
        #1;
        check("midrst_mem_write", 512'(mem_write), 512'(0));
        check("midrst_req_resp", 512'(req_resp), 512'(0));
        check("midrst_mem_address", 512'(mem_address), 512'(0));
        clr_req(1);
        mem_resp = 1'b0;
        rst      = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        push_req(1'b1, 1'b0, 32'h0000_0100, '0);
        push_rsp(0, {32{8'hE0}});
        step();
        check("post_rst_grant_read", 512'(mem_read), 512'(1));
        check("post_rst_grant_addr", 512'(mem_address), 512'(32'h0000_0100));
        serve(0, 1, {32{8'hE0}});

        repeat (3) step();
        check("exp_req_q_drained", 512'(exp_req_q.size()), 512'(0));
        check("exp_rsp_q_drained", 512'(exp_rsp_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
